// File: rtl/cfd_acq_sequencer.sv
// HINP4 CFD/TVC acquisition sequencer: force_rst, settle, CFD window, common_stop
// with veto_rst, serial readout on acq_clk, then re-arm. One shared 16-bit
// down-counter times every phase; a channel counter tracks readout pulses.
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   IDLE         | waiting for start
//   FRST         | force_rst high, T_FRST cycles
//   SETTLE       | all outputs low, T_SETTLE cycles
//   ARMED        | global_cfd_en high for the latched TVC window
//   STOP         | common_stop high, veto_rst rises after T_VETO_DLY
//   READ_HI      | acq_clk high phase of the current channel
//   READ_LO      | acq_clk low phase; strobe on its first cycle
//   REARM_FRST   | force_rst high again after readout
//   REARM_SETTLE | settle before re-arming or returning to IDLE
module cfd_acq_sequencer #(
   parameter int unsigned T_FRST     = 10,
   parameter int unsigned T_SETTLE   = 10,
   parameter int unsigned WIN_4U     = 114,
   parameter int unsigned WIN_1U     = 111,
   parameter int unsigned T_VETO_DLY = 2,
   parameter int unsigned T_STOP     = 50,
   parameter int unsigned T_ACQ_HALF = 8,
   parameter int unsigned N_CHAN     = 16
) (
   input  logic       clk,
   input  logic       dig_rst,
   input  logic       start,
   input  logic       abort,
   input  logic       tvc_mode,
   input  logic       continuous,
   input  logic       skip_empty,
   input  logic       trig,
   output logic       force_rst,
   output logic       global_cfd_en,
   output logic       common_stop,
   output logic       veto_rst,
   output logic       acq_clk,
   output logic       busy,
   output logic       hit_seen,
   output logic       chan_strobe,
   output logic [3:0] chan_idx,
   output logic       done
);

   localparam int unsigned CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

   // Counter load values are phase length minus one: a phase ends when cnt hits 0.
   localparam logic [15:0] L_FRST    = 16'(T_FRST - 1);
   localparam logic [15:0] L_SETTLE  = 16'(T_SETTLE - 1);
   localparam logic [15:0] L_WIN4    = 16'(WIN_4U - 1);
   localparam logic [15:0] L_WIN1    = 16'(WIN_1U - 1);
   localparam logic [15:0] L_STOP    = 16'(T_STOP - 1);
   localparam logic [15:0] L_ACQ     = 16'(T_ACQ_HALF - 1);
   localparam logic [15:0] VETO_AT   = 16'(T_STOP - T_VETO_DLY);
   localparam logic [CW-1:0] CHAN_LAST = CW'(N_CHAN - 1);

   typedef enum logic [3:0] {
      IDLE, FRST, SETTLE, ARMED, STOP, READ_HI, READ_LO, REARM_FRST, REARM_SETTLE
   } state_t;

   state_t        state, state_n;
   logic [15:0]   cnt, cnt_n;
   logic [CW-1:0] chan, chan_n;
   logic          mode_q, mode_n;
   logic          hit_n, veto_n, strobe_n, done_n;
   logic [3:0]    idx_n;
   logic [15:0]   win_load;
   logic          last;

   assign win_load = mode_q ? L_WIN4 : L_WIN1;
   assign last     = (cnt == 16'd0);

   // Next-state, counter and output computation; outputs are registered from these.
   always_comb begin
      state_n  = state;
      cnt_n    = last ? 16'd0 : cnt - 16'd1;
      chan_n   = chan;
      mode_n   = mode_q;
      hit_n    = hit_seen;
      veto_n   = veto_rst;
      strobe_n = 1'b0;
      idx_n    = chan_idx;
      done_n   = 1'b0;

      if (abort && state != IDLE) begin
         state_n = IDLE;
         cnt_n   = 16'd0;
         chan_n  = '0;
         hit_n   = 1'b0;
         veto_n  = 1'b0;
         idx_n   = 4'd0;
         done_n  = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  state_n = FRST;
                  cnt_n   = L_FRST;
                  mode_n  = tvc_mode;
                  chan_n  = '0;
               end
            end
            FRST: begin
               if (last) begin
                  state_n = SETTLE;
                  cnt_n   = L_SETTLE;
               end
            end
            SETTLE: begin
               if (last) begin
                  state_n = ARMED;
                  cnt_n   = win_load;
                  hit_n   = 1'b0;
               end
            end
            ARMED: begin
               if (trig) hit_n = 1'b1;
               if (last) begin
                  // A hit on the final window cycle still counts as non-empty.
                  if (skip_empty && !(hit_seen || trig)) begin
                     state_n = REARM_FRST;
                     cnt_n   = L_FRST;
                     mode_n  = tvc_mode;
                  end else begin
                     state_n = STOP;
                     cnt_n   = L_STOP;
                     veto_n  = (T_VETO_DLY == 0);
                  end
               end
            end
            STOP: begin
               if (cnt == VETO_AT) veto_n = 1'b1;
               if (last) begin
                  state_n = READ_HI;
                  cnt_n   = L_ACQ;
                  chan_n  = '0;
               end
            end
            READ_HI: begin
               if (last) begin
                  state_n  = READ_LO;
                  cnt_n    = L_ACQ;
                  strobe_n = 1'b1;
                  idx_n    = 4'(chan);
               end
            end
            READ_LO: begin
               if (last) begin
                  if (chan == CHAN_LAST) begin
                     state_n = REARM_FRST;
                     cnt_n   = L_FRST;
                     veto_n  = 1'b0;
                     mode_n  = tvc_mode;
                     chan_n  = '0;
                  end else begin
                     state_n = READ_HI;
                     cnt_n   = L_ACQ;
                     chan_n  = chan + 1'b1;
                  end
               end
            end
            REARM_FRST: begin
               if (last) begin
                  state_n = REARM_SETTLE;
                  cnt_n   = L_SETTLE;
               end
            end
            REARM_SETTLE: begin
               if (last) begin
                  if (continuous) begin
                     state_n = ARMED;
                     cnt_n   = win_load;
                     hit_n   = 1'b0;
                  end else begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = 16'd0;
            end
         endcase
      end
   end

   // State, counters and registered outputs; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      if (dig_rst) begin
         state         <= IDLE;
         cnt           <= 16'd0;
         chan          <= '0;
         mode_q        <= 1'b0;
         force_rst     <= 1'b0;
         global_cfd_en <= 1'b0;
         common_stop   <= 1'b0;
         veto_rst      <= 1'b0;
         acq_clk       <= 1'b0;
         busy          <= 1'b0;
         hit_seen      <= 1'b0;
         chan_strobe   <= 1'b0;
         chan_idx      <= 4'd0;
         done          <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         chan          <= chan_n;
         mode_q        <= mode_n;
         force_rst     <= (state_n == FRST) || (state_n == REARM_FRST);
         global_cfd_en <= (state_n == ARMED);
         common_stop   <= (state_n == STOP);
         veto_rst      <= veto_n;
         acq_clk       <= (state_n == READ_HI);
         busy          <= (state_n != IDLE);
         hit_seen      <= hit_n;
         chan_strobe   <= strobe_n;
         chan_idx      <= idx_n;
         done          <= done_n;
      end
   end

endmodule

// File: tb/tb_cfd_acq_sequencer.sv
// Directed bench for cfd_acq_sequencer. Cycle c is the clock period that
// follows edge c-1, where edge 0 is the edge sampling start.
module tb_cfd_acq_sequencer;

   logic       clk;
   logic       dig_rst, start, abort, tvc_mode, continuous, skip_empty, trig;
   logic       force_rst, global_cfd_en, common_stop, veto_rst, acq_clk;
   logic       busy, hit_seen, chan_strobe, done;
   logic [3:0] chan_idx;

   int n_cmp  = 0;
   int n_fail = 0;
   int cur    = 0;

   int viol      = 0;
   int acq_rise  = 0;
   int strobe_ct = 0;
   int stop_cyc  = 0;
   int veto_cyc  = 0;
   logic acq_prev = 1'b0;

   int s_acq, s_strobe, s_stop, s_veto;

   cfd_acq_sequencer dut (
      .clk           (clk),
      .dig_rst       (dig_rst),
      .start         (start),
      .abort         (abort),
      .tvc_mode      (tvc_mode),
      .continuous    (continuous),
      .skip_empty    (skip_empty),
      .trig          (trig),
      .force_rst     (force_rst),
      .global_cfd_en (global_cfd_en),
      .common_stop   (common_stop),
      .veto_rst      (veto_rst),
      .acq_clk       (acq_clk),
      .busy          (busy),
      .hit_seen      (hit_seen),
      .chan_strobe   (chan_strobe),
      .chan_idx      (chan_idx),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Activity counters and invariant watch, sampled mid-cycle.
   always @(negedge clk) begin
      if (global_cfd_en && common_stop) viol++;
      if (acq_clk && common_stop) viol++;
      if (acq_clk && !acq_prev) acq_rise++;
      if (chan_strobe) strobe_ct++;
      if (common_stop) stop_cyc++;
      if (veto_rst) veto_cyc++;
      acq_prev = acq_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cur < c) begin
         @(posedge clk);
         #1;
         cur++;
      end
   endtask

   task automatic kick();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cur = 1;
   endtask

   task automatic snap();
      s_acq    = acq_rise;
      s_strobe = strobe_ct;
      s_stop   = stop_cyc;
      s_veto   = veto_cyc;
   endtask

   task automatic wait_done(input string tag, input int exp_c);
      int lim;
      lim = exp_c + 20;
      while (!done && cur < lim) goto(cur + 1);
      chk(tag, cur, exp_c);
   endtask

   initial begin
      dig_rst = 1'b1; start = 1'b0; abort = 1'b0; tvc_mode = 1'b1;
      continuous = 1'b0; skip_empty = 1'b0; trig = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_force", force_rst, 0);
      chk("rst_cfd", global_cfd_en, 0);
      chk("rst_stop", common_stop, 0);
      chk("rst_veto", veto_rst, 0);
      chk("rst_acq", acq_clk, 0);
      chk("rst_busy", busy, 0);
      chk("rst_hit", hit_seen, 0);
      chk("rst_strobe", chan_strobe, 0);
      chk("rst_idx", chan_idx, 0);
      chk("rst_done", done, 0);
      dig_rst = 1'b0;
      @(posedge clk); #1;

      // abort alone in IDLE: no done; start+abort together: nothing happens
      abort = 1'b1;
      @(posedge clk); #1;
      chk("idle_abort_done", done, 0);
      chk("idle_abort_busy", busy, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", busy, 0);
      chk("sa_force", force_rst, 0);
      chk("sa_done", done, 0);
      @(posedge clk); #1;
      chk("sa_busy2", busy, 0);

      // Test 1: defaults, 4 us window, trig at cycle 60
      snap();
      kick();
      chk("t1_force_1", force_rst, 1);
      chk("t1_busy_1", busy, 1);
      tvc_mode = 1'b0;
      goto(10);  chk("t1_force_10", force_rst, 1);
      goto(11);  chk("t1_force_11", force_rst, 0);
      goto(20);  chk("t1_cfd_20", global_cfd_en, 0);
      goto(21);  chk("t1_cfd_21", global_cfd_en, 1);
      goto(50);  start = 1'b1;
      goto(51);  start = 1'b0;
      goto(60);  chk("t1_hit_60", hit_seen, 0); trig = 1'b1;
      goto(61);  trig = 1'b0; chk("t1_hit_61", hit_seen, 1);
      goto(134); chk("t1_cfd_134", global_cfd_en, 1);
                 chk("t1_stop_134", common_stop, 0);
      goto(135); chk("t1_cfd_135", global_cfd_en, 0);
                 chk("t1_stop_135", common_stop, 1);
      goto(136); chk("t1_veto_136", veto_rst, 0);
      goto(137); chk("t1_veto_137", veto_rst, 1);
      goto(184); chk("t1_stop_184", common_stop, 1);
                 chk("t1_acq_184", acq_clk, 0);
      goto(185); chk("t1_stop_185", common_stop, 0);
                 chk("t1_acq_185", acq_clk, 1);
      goto(192); chk("t1_acq_192", acq_clk, 1);
                 chk("t1_strobe_192", chan_strobe, 0);
      goto(193); chk("t1_acq_193", acq_clk, 0);
                 chk("t1_strobe_193", chan_strobe, 1);
                 chk("t1_idx_193", chan_idx, 0);
      goto(194); chk("t1_strobe_194", chan_strobe, 0);
      goto(201); chk("t1_acq_201", acq_clk, 1);
      goto(209); chk("t1_strobe_209", chan_strobe, 1);
                 chk("t1_idx_209", chan_idx, 1);
      goto(433); chk("t1_strobe_433", chan_strobe, 1);
                 chk("t1_idx_433", chan_idx, 15);
      goto(440); chk("t1_veto_440", veto_rst, 1);
                 chk("t1_force_440", force_rst, 0);
      goto(441); chk("t1_veto_441", veto_rst, 0);
                 chk("t1_force_441", force_rst, 1);
      goto(450); chk("t1_force_450", force_rst, 1);
      goto(451); chk("t1_force_451", force_rst, 0);
      goto(460); chk("t1_done_460", done, 0);
                 chk("t1_busy_460", busy, 1);
      goto(461); chk("t1_done_461", done, 1);
                 chk("t1_busy_461", busy, 0);
      goto(462); chk("t1_done_462", done, 0);
      chk("t1_acq_pulses", acq_rise - s_acq, 16);
      chk("t1_strobes", strobe_ct - s_strobe, 16);
      chk("t1_stop_cycles", stop_cyc - s_stop, 50);
      chk("t1_veto_cycles", veto_cyc - s_veto, 304);

      // Test 2: 1 us window, tvc_mode changed after the latch edge
      tvc_mode = 1'b0;
      kick();
      tvc_mode = 1'b1;
      goto(21);  chk("t2_cfd_21", global_cfd_en, 1);
      goto(131); chk("t2_cfd_131", global_cfd_en, 1);
      goto(132); chk("t2_cfd_132", global_cfd_en, 0);
                 chk("t2_stop_132", common_stop, 1);
      wait_done("t2_done_cycle", 458);

      // Test 3: skip_empty with no trig
      skip_empty = 1'b1;
      snap();
      kick();
      goto(134); chk("t3_cfd_134", global_cfd_en, 1);
      goto(135); chk("t3_cfd_135", global_cfd_en, 0);
                 chk("t3_force_135", force_rst, 1);
                 chk("t3_stop_135", common_stop, 0);
      goto(144); chk("t3_force_144", force_rst, 1);
      goto(145); chk("t3_force_145", force_rst, 0);
      goto(154); chk("t3_done_154", done, 0);
      goto(155); chk("t3_done_155", done, 1);
                 chk("t3_busy_155", busy, 0);
      chk("t3_no_stop", stop_cyc - s_stop, 0);
      chk("t3_no_veto", veto_cyc - s_veto, 0);
      chk("t3_no_acq", acq_rise - s_acq, 0);
      skip_empty = 1'b0;
      goto(157);

      // Test 4: continuous re-arm, tvc re-latched at re-arm force_rst rise
      continuous = 1'b1;
      kick();
      goto(60);  trig = 1'b1;
      goto(61);  trig = 1'b0;
      goto(300); tvc_mode = 1'b0;
      goto(450); chk("t4_force_450", force_rst, 1);
      goto(451); chk("t4_force_451", force_rst, 0);
      goto(460); chk("t4_cfd_460", global_cfd_en, 0);
                 chk("t4_hit_460", hit_seen, 1);
      goto(461); chk("t4_cfd_461", global_cfd_en, 1);
                 chk("t4_hit_461", hit_seen, 0);
                 chk("t4_done_461", done, 0);
                 chk("t4_busy_461", busy, 1);
      tvc_mode = 1'b1;
      goto(571); chk("t4_cfd_571", global_cfd_en, 1);
      goto(572); chk("t4_cfd_572", global_cfd_en, 0);
                 chk("t4_stop_572", common_stop, 1);
      continuous = 1'b0;
      abort = 1'b1;
      goto(573); abort = 1'b0;
                 chk("t4_ab_stop", common_stop, 0);
                 chk("t4_ab_busy", busy, 0);
                 chk("t4_ab_done", done, 1);
      goto(574); chk("t4_ab_done2", done, 0);

      // Test 5: abort during READ_HI of pulse 5, then a full fresh cycle
      kick();
      goto(267); chk("t5_acq_267", acq_clk, 1);
                 chk("t5_veto_267", veto_rst, 1);
                 abort = 1'b1;
      goto(268); abort = 1'b0;
                 chk("t5_acq_268", acq_clk, 0);
                 chk("t5_veto_268", veto_rst, 0);
                 chk("t5_busy_268", busy, 0);
                 chk("t5_done_268", done, 1);
      goto(269); chk("t5_done_269", done, 0);
      snap();
      kick();
      chk("t5r_force_1", force_rst, 1);
      goto(193); chk("t5r_strobe_193", chan_strobe, 1);
                 chk("t5r_idx_193", chan_idx, 0);
      wait_done("t5r_done_cycle", 461);
      chk("t5r_acq_pulses", acq_rise - s_acq, 16);

      // Test 6: dig_rst during STOP
      kick();
      goto(60);  trig = 1'b1;
      goto(61);  trig = 1'b0;
      goto(150); chk("t6_stop_150", common_stop, 1);
                 dig_rst = 1'b1;
      goto(151); chk("t6_stop_151", common_stop, 0);
                 chk("t6_veto_151", veto_rst, 0);
                 chk("t6_busy_151", busy, 0);
                 chk("t6_hit_151", hit_seen, 0);
                 chk("t6_done_151", done, 0);
      goto(153); dig_rst = 1'b0;
      goto(156); chk("t6_busy_156", busy, 0);
                 chk("t6_done_156", done, 0);
                 chk("t6_force_156", force_rst, 0);

      chk("invariant_viol", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
